bank_rr_arb: RTL

Per-bank arbitration and response stage of the TCDM full crossbar: sits directly downstream of the master-side address decoders, one instance per bank. It collects the decoded request lines of all masters targeting one bank, grants one per cycle with a round-robin policy, drives the single-port SRAM, and returns read data exactly `RespLat` cycles after the grant. That latency is the value the master-side response muxes are configured with.

---
 rtl/tcdm_pkg.sv | 21 ++
 rtl/bank_rr_pick.sv | 47 ++++
 rtl/bank_rr_arb.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/tcdm_pkg.sv
// Shared TCDM crossbar types and helpers: round-robin index sizing and the
// modulo-NumIn pointer increment used by the per-bank arbiters.
package tcdm_pkg;

    localparam int unsigned DefNumIn = 32;

    // Index width for n masters, never below one bit so single-master banks still have a type.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned RrIdxW = idx_width(DefNumIn);

    typedef logic [RrIdxW-1:0] rr_idx_t;

    // Wraps explicitly at n so non-power-of-two master counts never reach an unused index.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bank_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer,
// falling back to the first set request overall.
module bank_rr_pick #(
    parameter int unsigned NumIn = 32,
    parameter int unsigned IdxW  = 5
) (
    input  logic [NumIn-1:0] req_i,
    input  logic [IdxW-1:0]  ptr_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             valid_o
);

    logic [NumIn-1:0] masked;
    logic [IdxW-1:0]  m_idx;
    logic [IdxW-1:0]  u_idx;
    logic             m_vld;
    logic             u_vld;

    always_comb begin
        masked = '0;
        for (int i = 0; i < int'(NumIn); i++) begin
            masked[i] = req_i[i] && (IdxW'(i) >= ptr_i);
        end
    end

    // Scanning downwards so the lowest set bit is the last one written.
    always_comb begin
        m_idx = '0;
        m_vld = 1'b0;
        u_idx = '0;
        u_vld = 1'b0;
        for (int i = int'(NumIn) - 1; i >= 0; i--) begin
            if (masked[i]) begin
                m_idx = IdxW'(i);
                m_vld = 1'b1;
            end
            if (req_i[i]) begin
                u_idx = IdxW'(i);
                u_vld = 1'b1;
            end
        end
    end

    assign idx_o   = m_vld ? m_idx : u_idx;
    assign valid_o = u_vld;

endmodule

// File: rtl/bank_rr_arb.sv
// Per-bank round-robin arbiter and read-response pipeline for the TCDM crossbar.
// Optional conflict counter enabled by defining BANK_ARB_PERF_CNT_EN.
module bank_rr_arb
    import tcdm_pkg::*;
#(
    parameter int unsigned NumIn         = 32,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32,
    parameter int unsigned RespLat       = 1,
    parameter int unsigned CntWidth      = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumIn-1:0]                    req_i,
    input  logic [NumIn-1:0][ReqDataWidth-1:0]  data_i,
    output logic [NumIn-1:0]                    gnt_o,
    output logic [RespDataWidth-1:0]            rdata_o,
    output logic                                mem_req_o,
    output logic [ReqDataWidth-1:0]             mem_data_o,
    input  logic [RespDataWidth-1:0]            mem_rdata_i,
    input  logic                                cnt_clr_i,
    output logic [CntWidth-1:0]                 conflict_cnt_o
);

    localparam int unsigned IdxW   = idx_width(NumIn);
    localparam int unsigned NumStg = (RespLat > 1) ? RespLat - 1 : 1;

    logic [IdxW-1:0] win_idx;
    logic            win_vld;

    generate
        if (NumIn == 1) begin : g_single
            assign win_idx = '0;
            assign win_vld = req_i[0];
        end else begin : g_rr
            logic [IdxW-1:0] rr_q;
            logic [IdxW-1:0] rr_d;

            bank_rr_pick #(
                .NumIn (NumIn),
                .IdxW  (IdxW)
            ) u_pick (
                .req_i   (req_i),
                .ptr_i   (rr_q),
                .idx_o   (win_idx),
                .valid_o (win_vld)
            );

            always_comb begin
                rr_d = rr_q;
                if (win_vld) begin
                    rr_d = IdxW'(rr_next(32'(win_idx), NumIn));
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    rr_q <= '0;
                end else begin
                    rr_q <= rr_d;
                end
            end
        end
    endgenerate

    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < int'(NumIn); i++) begin
            gnt_o[i] = win_vld && (win_idx == IdxW'(i));
        end
    end

    assign mem_req_o  = |req_i;
    assign mem_data_o = win_vld ? data_i[win_idx] : '0;

    generate
        if (RespLat == 1) begin : g_comb_resp
            assign rdata_o = mem_rdata_i;
        end else begin : g_pipe_resp
            logic [NumStg-1:0]        vld_q;
            logic [NumStg-1:0]        vld_d;
            logic [RespDataWidth-1:0] dat_q [NumStg];
            logic [RespDataWidth-1:0] dat_d [NumStg];

            // vld_q[i] marks that the input of data stage i is valid this cycle.
            always_comb begin
                vld_d[0] = mem_req_o;
                dat_d[0] = vld_q[0] ? mem_rdata_i : dat_q[0];
                for (int unsigned i = 1; i < NumStg; i++) begin
                    vld_d[i] = vld_q[i-1];
                    dat_d[i] = vld_q[i] ? dat_q[i-1] : dat_q[i];
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld_q <= '0;
                    for (int unsigned i = 0; i < NumStg; i++) begin
                        dat_q[i] <= '0;
                    end
                end else begin
                    vld_q <= vld_d;
                    for (int unsigned i = 0; i < NumStg; i++) begin
                        dat_q[i] <= dat_d[i];
                    end
                end
            end

            assign rdata_o = dat_q[NumStg-1];
        end
    endgenerate

`ifdef BANK_ARB_PERF_CNT_EN
    logic                conflict;
    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] cnt_d;

    // More than one bit set iff clearing the lowest set bit leaves something.
    assign conflict = |(req_i & (req_i - NumIn'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (conflict && (cnt_q != '1)) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conflict_cnt_o = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr_i;
    assign conflict_cnt_o = '0;
`endif

endmodule
